// File: rtl/matvec_arbiter.sv
// matvec_arbiter
//
// Round-robin arbiter that lets two independent client streams share one
// matrix-vector engine. A client keeps the engine for one complete job:
// S*S matrix words and S vector words go in, then S results come out.
// Arbitration happens only between jobs, so each client sees the engine as if
// it were private. The data path has no storage. Words and handshakes pass
// straight through, and the FSM only selects which client is connected.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   req{0,1}_valid/ready/data  client input word streams (IW bits)
//   rsp{0,1}_valid/ready/data  client result streams (OW bits)
//   eng_in_valid/ready/data    input handshake toward the engine
//   eng_out_valid/ready/data   result handshake from the engine
//   busy                       a job is in progress (state != IDLE)
//   grant                      index of the client holding the engine
//
// state | meaning
// IDLE  | no job owned; arbitrate between pending clients
// LOAD  | granted client streams S*S+S words into the engine
// DRAIN | engine returns S results to the granted client

module matvec_arbiter #(
  parameter int S  = 3,
  parameter int IW = 14,
  parameter int OW = 28
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [IW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [IW-1:0] req1_data,

  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [OW-1:0] rsp0_data,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [OW-1:0] rsp1_data,

  output logic          eng_in_valid,
  input  logic          eng_in_ready,
  output logic [IW-1:0] eng_in_data,
  input  logic          eng_out_valid,
  output logic          eng_out_ready,
  input  logic [OW-1:0] eng_out_data,

  output logic          busy,
  output logic          grant
);

  localparam int JOB_IN = S * S + S;
  localparam int CW_IN  = $clog2(JOB_IN + 1);
  localparam int CW_OUT = $clog2(S + 1);

  localparam logic [CW_IN-1:0]  IN_LAST  = CW_IN'(JOB_IN - 1);
  localparam logic [CW_OUT-1:0] OUT_LAST = CW_OUT'(S - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [CW_IN-1:0]    in_cnt_q, in_cnt_d;
  logic [CW_OUT-1:0]   out_cnt_q, out_cnt_d;

  logic                sel_req_valid;
  logic                sel_rsp_ready;
  logic                in_hs;
  logic                out_hs;

  // last_grant resets to 1 so that client 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  assign sel_req_valid = grant_q ? req1_valid : req0_valid;
  assign sel_rsp_ready = grant_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;

    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp0_valid    = 1'b0;
    rsp1_valid    = 1'b0;
    eng_in_valid  = 1'b0;
    eng_out_ready = 1'b0;
    in_hs         = 1'b0;
    out_hs        = 1'b0;

    case (state_q)
      IDLE: begin
        // Nothing moves in IDLE. The grant registers here and data starts
        // flowing in the next cycle.
        if (req0_valid | req1_valid) begin
          if (req0_valid & req1_valid) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = req1_valid;
          end
          state_d  = LOAD;
          in_cnt_d = '0;
        end
      end

      LOAD: begin
        eng_in_valid = sel_req_valid;
        req0_ready   = ~grant_q & eng_in_ready;
        req1_ready   = grant_q & eng_in_ready;
        in_hs        = eng_in_valid & eng_in_ready;
        if (in_hs) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == IN_LAST) begin
            state_d   = DRAIN;
            out_cnt_d = '0;
          end
        end
      end

      DRAIN: begin
        rsp0_valid    = ~grant_q & eng_out_valid;
        rsp1_valid    = grant_q & eng_out_valid;
        eng_out_ready = sel_rsp_ready;
        out_hs        = eng_out_valid & eng_out_ready;
        if (out_hs) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == OUT_LAST) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Data is always muxed or broadcast. Only the valid and ready signals
  // decide who may use it.
  assign eng_in_data = grant_q ? req1_data : req0_data;
  assign rsp0_data   = eng_out_data;
  assign rsp1_data   = eng_out_data;

  assign busy  = (state_q != IDLE);
  assign grant = grant_q;

endmodule

// File: tb/tb_matvec_arbiter.sv
module tb_matvec_arbiter;

  localparam int S  = 3;
  localparam int IW = 14;
  localparam int OW = 28;
  localparam int NIN = S * S + S;
  localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (OW - 1));

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [IW-1:0] req0_data, req1_data;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [OW-1:0] rsp0_data, rsp1_data;
  logic          eng_in_valid, eng_in_ready, eng_out_valid, eng_out_ready;
  logic [IW-1:0] eng_in_data;
  logic [OW-1:0] eng_out_data;
  logic          busy, grant;

  int total = 0;
  int bad   = 0;

  logic [IW-1:0] src0[$], src1[$];
  logic [OW-1:0] exp0[$], exp1[$];
  logic          exp_grant[$];

  logic hold0   = 1'b0;
  logic gap0_en = 1'b0;
  logic mon_en  = 1'b0;
  logic prev_busy = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  matvec_arbiter #(.S(S), .IW(IW), .OW(OW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data),
    .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready), .eng_out_data(eng_out_data),
    .busy(busy), .grant(grant)
  );

  // Behavioural matvec engine: collects W row-major then x, saturates results.
  logic                 eng_phase;
  int                   e_cnt, o_cnt;
  logic signed [IW-1:0] mem [NIN];
  logic [OW-1:0]        y [S];

  assign eng_in_ready  = !eng_phase;
  assign eng_out_valid = eng_phase;
  assign eng_out_data  = y[o_cnt];

  function automatic logic [OW-1:0] row_result(input int r);
    longint acc;
    longint xv;
    acc = 0;
    for (int c = 0; c < S; c++) begin
      if (c == S - 1) xv = longint'($signed(eng_in_data));
      else            xv = longint'(mem[S * S + c]);
      acc += longint'(mem[r * S + c]) * xv;
    end
    if (acc > OMAX) acc = OMAX;
    if (acc < OMIN) acc = OMIN;
    return OW'(acc);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      eng_phase <= 1'b0;
      e_cnt     <= 0;
      o_cnt     <= 0;
    end else if (!eng_phase) begin
      if (eng_in_valid && eng_in_ready) begin
        mem[e_cnt] <= $signed(eng_in_data);
        if (e_cnt == NIN - 1) begin
          for (int r = 0; r < S; r++) y[r] <= row_result(r);
          eng_phase <= 1'b1;
          e_cnt     <= 0;
          o_cnt     <= 0;
        end else begin
          e_cnt <= e_cnt + 1;
        end
      end
    end else if (eng_out_valid && eng_out_ready) begin
      if (o_cnt == S - 1) begin
        eng_phase <= 1'b0;
        o_cnt     <= 0;
      end else begin
        o_cnt <= o_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Client drivers: present the head of each source queue just after the edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    req0_valid = (src0.size() > 0) && !(gap0_en && (cyc % 3 == 0));
    req0_data  = (src0.size() > 0) ? src0[0] : '0;
    req1_valid = (src1.size() > 0);
    req1_data  = (src1.size() > 0) ? src1[0] : '0;
    rsp0_ready = !hold0;
    rsp1_ready = 1'b1;
  end

  // Monitor at the falling edge: handshakes seen here complete on the next rise.
  always @(negedge clk) begin
    logic [OW-1:0] e;
    logic          g;
    if (req0_valid && req0_ready && src0.size() > 0) void'(src0.pop_front());
    if (req1_valid && req1_ready && src1.size() > 0) void'(src1.pop_front());
    if (rsp0_valid && rsp0_ready) begin
      if (exp0.size() == 0) chk("rsp0_extra_word", 32'(rsp0_data), 32'hDEAD0000);
      else begin
        e = exp0.pop_front();
        chk("rsp0_data", 32'(rsp0_data), 32'(e));
      end
    end
    if (rsp1_valid && rsp1_ready) begin
      if (exp1.size() == 0) chk("rsp1_extra_word", 32'(rsp1_data), 32'hDEAD0001);
      else begin
        e = exp1.pop_front();
        chk("rsp1_data", 32'(rsp1_data), 32'(e));
      end
    end
    if (mon_en && !reset) begin
      if (busy && !prev_busy) begin
        if (exp_grant.size() == 0) chk("grant_unexpected_job", 32'(grant), 32'hDEAD0002);
        else begin
          g = exp_grant.pop_front();
          chk("grant_order", 32'(grant), 32'(g));
        end
      end
      chk("idle_quiet", 32'(!busy && (req0_ready || req1_ready || rsp0_valid ||
          rsp1_valid || eng_in_valid || eng_out_ready)), 32'd0);
      chk("ungranted_quiet", 32'(busy && (grant ? (req0_ready || rsp0_valid)
          : (req1_ready || rsp1_valid))), 32'd0);
    end
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_job(input int cl, input int w[9], input int x[3], input int e[3]);
    for (int i = 0; i < 9; i++) begin
      if (cl == 0) src0.push_back(IW'(w[i]));
      else         src1.push_back(IW'(w[i]));
    end
    for (int i = 0; i < 3; i++) begin
      if (cl == 0) begin src0.push_back(IW'(x[i])); exp0.push_back(OW'(e[i])); end
      else         begin src1.push_back(IW'(x[i])); exp1.push_back(OW'(e[i])); end
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (src0.size() == 0 && src1.size() == 0 && exp0.size() == 0 && exp1.size() == 0)
        break;
    end
    chk(tag, 32'(i < budget), 32'd1);
  endtask

  // which: 0 = exp0 size, 1 = src0 size
  task automatic wait_size(input string tag, input int which, input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if ((which == 0 ? exp0.size() : src0.size()) == n) break;
    end
    chk(tag, 32'(i < budget), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_req_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("reset_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk("reset_eng_hs", 32'({eng_in_valid, eng_out_ready}), 32'd0);
    mon_en = 1'b1;

    // Single client: identity matrix, x = 1,2,3.
    exp_grant.push_back(1'b0);
    push_job(0, '{1,0,0, 0,1,0, 0,0,1}, '{1,2,3}, '{1,2,3});
    wait_done("single_job_timeout", 200);
    chk("busy_after_last_result", 32'(busy), 32'd0);

    // Tie right after reset: client 0 first, then client 1.
    do_reset();
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    push_job(0, '{1,0,0, 0,1,0, 0,0,1}, '{4,5,6}, '{4,5,6});
    push_job(1, '{2,2,2, 2,2,2, 2,2,2}, '{1,1,1}, '{6,6,6});
    wait_done("tie_jobs_timeout", 300);

    // Continuous contention for four jobs.
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    push_job(0, '{1,0,0, 0,1,0, 0,0,1}, '{7,8,9}, '{7,8,9});
    push_job(0, '{1,2,3, 0,1,0, -1,0,0}, '{1,1,1}, '{6,1,-1});
    push_job(1, '{2,2,2, 2,2,2, 2,2,2}, '{1,1,1}, '{6,6,6});
    push_job(1, '{3,0,0, 0,3,0, 0,0,3}, '{2,-2,1}, '{6,-6,3});
    wait_done("contention_timeout", 500);

    // Backpressure: input gaps during LOAD, result stall mid-DRAIN.
    gap0_en = 1'b1;
    exp_grant.push_back(1'b0);
    push_job(0, '{1,0,0, 0,1,0, 0,0,1}, '{10,11,12}, '{10,11,12});
    wait_size("stall_wait_timeout", 0, 2, 300);
    hold0 = 1'b1;
    repeat (5) tick();
    chk("stall_results_left", 32'(exp0.size()), 32'd1);
    chk("stall_valid_held", 32'(rsp0_valid), 32'd1);
    chk("stall_busy", 32'(busy), 32'd1);
    hold0 = 1'b0;
    wait_done("stall_job_timeout", 200);
    gap0_en = 1'b0;

    // Reset after 7 of 12 input words, then a fresh job from client 1.
    exp_grant.push_back(1'b0);
    push_job(0, '{5,5,5, 5,5,5, 5,5,5}, '{1,1,1}, '{15,15,15});
    wait_size("partial_load_timeout", 1, 5, 200);
    reset = 1'b1;
    src0.delete();
    exp0.delete();
    tick();
    chk("midjob_reset_busy", 32'(busy), 32'd0);
    chk("midjob_reset_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("midjob_reset_grant", 32'(grant), 32'd0);
    reset = 1'b0;
    tick();
    exp_grant.push_back(1'b1);
    push_job(1, '{2,2,2, 2,2,2, 2,2,2}, '{1,2,3}, '{12,12,12});
    wait_done("post_reset_job_timeout", 200);

    // Saturated engine output passes through unmodified.
    exp_grant.push_back(1'b0);
    push_job(0, '{8191,8191,8191, 8191,8191,8191, 8191,8191,8191}, '{8191,8191,8191},
             '{32'h7FFFFFF, 32'h7FFFFFF, 32'h7FFFFFF});
    wait_done("saturation_timeout", 200);

    repeat (3) tick();
    chk("grant_checks_left", 32'(exp_grant.size()), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
